// File: rtl/loop_mon_pkg.sv
// loop_mon_pkg: shared types and defaults for loop_osc_monitor.
// Optional feature macro: LOOP_MON_SYNC_EN (see loop_osc_monitor.sv).
package loop_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_OBSERVE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam int DEF_WIDTH         = 3;
    localparam int DEF_SETTLE_CYCLES = 4;
    localparam int DEF_WINDOW        = 16;
    localparam int DEF_CNT_W         = 8;
    localparam int DEF_OSC_THRESH    = 2;

    // Width of the phase counter shared by SETTLE and OBSERVE; it must
    // hold values 0 .. max(settle, window)-1 and is never narrower than 1.
    function automatic int phase_cnt_w(input int settle, input int window);
        int m;
        m = (settle > window) ? settle : window;
        if (m <= 2) return 1;
        return $clog2(m);
    endfunction

endpackage

// File: rtl/loop_mon_sync.sv
// loop_mon_sync: WIDTH-bit two-flop synchronizer with async active-high reset.
// Used by loop_osc_monitor only when LOOP_MON_SYNC_EN is defined.
module loop_mon_sync #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // Two back-to-back flops to resolve metastability of free-running nets.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/loop_osc_monitor.sv
// loop_osc_monitor: clocked observer for combinational-loop nets.
// After an accepted start it waits SETTLE_CYCLES, counts changing cycles
// over WINDOW cycles and reports stable / oscillating / final value.
// Optional macro LOOP_MON_SYNC_EN: route probe through a 2-flop synchronizer.
module loop_osc_monitor
    import loop_mon_pkg::*;
#(
    parameter int WIDTH         = DEF_WIDTH,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int WINDOW        = DEF_WINDOW,
    parameter int CNT_W         = DEF_CNT_W,
    parameter int OSC_THRESH    = DEF_OSC_THRESH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] probe,
    output logic             busy,
    output logic             done,
    output logic             result_valid,
    output logic             stable,
    output logic             oscillating,
    output logic [CNT_W-1:0] toggle_cnt,
    output logic [WIDTH-1:0] toggle_mask,
    output logic [WIDTH-1:0] final_value
);

    localparam int PH_W = phase_cnt_w(SETTLE_CYCLES, WINDOW);
    localparam logic [PH_W-1:0]  SETTLE_LAST = PH_W'(SETTLE_CYCLES - 1);
    localparam logic [PH_W-1:0]  WINDOW_LAST = PH_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    state_t           r_state;
    logic [PH_W-1:0]  r_phase;
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] w_sample;
    logic             w_changed;
    logic             w_obs_last;
    logic [CNT_W-1:0] w_cnt_next;

`ifdef LOOP_MON_SYNC_EN
    loop_mon_sync #(.WIDTH(WIDTH)) u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (probe),
        .o_q (w_sample)
    );
`else
    assign w_sample = probe;
`endif

    assign w_changed  = (w_sample != r_prev);
    assign w_obs_last = (r_state == ST_OBSERVE) && (r_phase == WINDOW_LAST);
    // Saturating count of changing cycles; multi-bit changes count once.
    assign w_cnt_next = (w_changed && (toggle_cnt != CNT_MAX)) ?
                        toggle_cnt + CNT_W'(1) : toggle_cnt;

    assign busy = (r_state == ST_SETTLE) || (r_state == ST_OBSERVE);
    assign done = (r_state == ST_DONE);

    // Previous-sample register; tracks in every state so SETTLE primes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_prev <= '0;
        else     r_prev <= w_sample;
    end

    // Phase sequencing; one counter times both SETTLE and OBSERVE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_phase <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_phase <= '0;
                    if (start) r_state <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (r_phase == SETTLE_LAST) begin
                        r_phase <= '0;
                        r_state <= ST_OBSERVE;
                    end else begin
                        r_phase <= r_phase + PH_W'(1);
                    end
                end
                ST_OBSERVE: begin
                    if (r_phase == WINDOW_LAST) begin
                        r_phase <= '0;
                        r_state <= ST_DONE;
                    end else begin
                        r_phase <= r_phase + PH_W'(1);
                    end
                end
                default: begin
                    r_phase <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Result accumulation; verdicts are latched as the window closes so
    // they appear together with the done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_valid <= 1'b0;
            stable       <= 1'b0;
            oscillating  <= 1'b0;
            toggle_cnt   <= '0;
            toggle_mask  <= '0;
            final_value  <= '0;
        end else if ((r_state == ST_IDLE) && start) begin
            result_valid <= 1'b0;
            stable       <= 1'b0;
            oscillating  <= 1'b0;
            toggle_cnt   <= '0;
            toggle_mask  <= '0;
            final_value  <= '0;
        end else if (r_state == ST_OBSERVE) begin
            toggle_cnt  <= w_cnt_next;
            toggle_mask <= toggle_mask | (w_sample ^ r_prev);
            if (w_obs_last) begin
                final_value  <= w_sample;
                result_valid <= 1'b1;
                stable       <= (w_cnt_next == '0);
                oscillating  <= (int'(w_cnt_next) >= OSC_THRESH);
            end
        end
    end

endmodule

// File: tb/tb_loop_osc_monitor.sv
// tb_loop_osc_monitor: table-driven directed bench for loop_osc_monitor
// (default build) plus hand-written saturation / ignored-start / reset cases.
module tb_loop_osc_monitor;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [2:0] probe;

    logic       busy, done, result_valid, stable, oscillating;
    logic [7:0] toggle_cnt;
    logic [2:0] toggle_mask, final_value;

    logic       busy3, done3, result_valid3, stable3, oscillating3;
    logic [2:0] toggle_cnt3;
    logic [2:0] toggle_mask3, final_value3;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    loop_osc_monitor dut (
        .clk(clk), .rst(rst), .start(start), .probe(probe),
        .busy(busy), .done(done), .result_valid(result_valid),
        .stable(stable), .oscillating(oscillating), .toggle_cnt(toggle_cnt),
        .toggle_mask(toggle_mask), .final_value(final_value)
    );

    loop_osc_monitor #(.CNT_W(3)) dut3 (
        .clk(clk), .rst(rst), .start(start), .probe(probe),
        .busy(busy3), .done(done3), .result_valid(result_valid3),
        .stable(stable3), .oscillating(oscillating3), .toggle_cnt(toggle_cnt3),
        .toggle_mask(toggle_mask3), .final_value(final_value3)
    );

    typedef struct {
        string      name;
        logic [2:0] init;
        logic [2:0] tmask;
        int         chg_cyc;
        logic [2:0] chg_val;
        int         chg2_cyc;
        logic [2:0] chg2_val;
        int         exp_cnt;
        logic [2:0] exp_mask;
        logic       exp_stable;
        logic       exp_osc;
        logic [2:0] exp_final;
    } vec_t;

    vec_t vecs[10];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] probe_at(input vec_t v, input int n);
        logic [2:0] p;
        p = v.init ^ ((n % 2 == 1) ? v.tmask : 3'b000);
        if (n >= v.chg_cyc)  p = v.chg_val;
        if (n >= v.chg2_cyc) p = v.chg2_val;
        return p;
    endfunction

    // Start in cycle 0, drive the per-cycle probe pattern, check timing and results.
    task automatic run_vec(input vec_t v);
        start = 1'b1;
        probe = v.init;
        step();
        start = 1'b0;
        for (int n = 1; n <= 22; n++) begin
            probe = probe_at(v, n);
            if (n == 1) check({v.name, ".busy_c1"}, busy, 1);
            if (n == 20) begin
                check({v.name, ".busy_c20"}, busy, 1);
                check({v.name, ".done_c20"}, done, 0);
            end
            if (n == 21) begin
                check({v.name, ".done_c21"}, done, 1);
                check({v.name, ".busy_c21"}, busy, 0);
                check({v.name, ".rv"}, result_valid, 1);
                check({v.name, ".cnt"}, toggle_cnt, v.exp_cnt);
                check({v.name, ".mask"}, toggle_mask, v.exp_mask);
                check({v.name, ".stable"}, stable, v.exp_stable);
                check({v.name, ".osc"}, oscillating, v.exp_osc);
                check({v.name, ".final"}, final_value, v.exp_final);
            end
            if (n == 22) begin
                check({v.name, ".done_c22"}, done, 0);
                check({v.name, ".rv_hold"}, result_valid, 1);
                check({v.name, ".final_hold"}, final_value, v.exp_final);
            end
            step();
        end
    endtask

    initial begin
        int done_cnt;
        int done_cyc;

        //               name               init    tmask   chg  val     chg2 val2    cnt mask   st  osc final
        vecs[0] = '{"const101",        3'b101, 3'b000, 99, 3'b000, 99, 3'b000,  0, 3'b000, 1, 0, 3'b101};
        vecs[1] = '{"tog_b0",          3'b000, 3'b001, 99, 3'b000, 99, 3'b000, 16, 3'b001, 0, 1, 3'b000};
        vecs[2] = '{"single_mid",      3'b000, 3'b000, 10, 3'b110, 99, 3'b000,  1, 3'b110, 0, 0, 3'b110};
        vecs[3] = '{"settle_chg",      3'b000, 3'b000,  2, 3'b011, 99, 3'b000,  0, 3'b000, 1, 0, 3'b011};
        vecs[4] = '{"chg_last_settle", 3'b000, 3'b000,  4, 3'b111, 99, 3'b000,  0, 3'b000, 1, 0, 3'b111};
        vecs[5] = '{"chg_first_obs",   3'b000, 3'b000,  5, 3'b111, 99, 3'b000,  1, 3'b111, 0, 0, 3'b111};
        vecs[6] = '{"chg_last_obs",    3'b010, 3'b000, 20, 3'b100, 99, 3'b000,  1, 3'b110, 0, 0, 3'b100};
        vecs[7] = '{"chg_in_done",     3'b010, 3'b000, 21, 3'b100, 99, 3'b000,  0, 3'b000, 1, 0, 3'b010};
        vecs[8] = '{"tog_2bits",       3'b111, 3'b011, 99, 3'b000, 99, 3'b000, 16, 3'b011, 0, 1, 3'b111};
        vecs[9] = '{"two_chg_thresh",  3'b000, 3'b000,  8, 3'b001, 12, 3'b000,  2, 3'b001, 0, 1, 3'b000};

        rst = 1'b1; start = 1'b0; probe = 3'b000;
        step(); step();
        check("rst.busy", busy, 0);
        check("rst.done", done, 0);
        check("rst.rv", result_valid, 0);
        check("rst.stable", stable, 0);
        check("rst.osc", oscillating, 0);
        check("rst.cnt", toggle_cnt, 0);
        check("rst.mask", toggle_mask, 0);
        check("rst.final", final_value, 0);
        rst = 1'b0;
        step();

        foreach (vecs[i]) run_vec(vecs[i]);

        // Saturation on the CNT_W=3 instance plus an ignored start in cycle 5.
        done_cnt = 0; done_cyc = -1;
        start = 1'b1; probe = 3'b000;
        step();
        start = 1'b0;
        for (int n = 1; n <= 30; n++) begin
            probe = (n % 2 == 1) ? 3'b001 : 3'b000;
            start = (n == 5);
            if (done3) begin
                done_cnt++;
                done_cyc = n;
            end
            if (n == 21) begin
                check("sat.cnt3", toggle_cnt3, 7);
                check("sat.osc3", oscillating3, 1);
                check("sat.stable3", stable3, 0);
                check("sat.mask3", toggle_mask3, 3'b001);
                check("sat.cnt8", toggle_cnt, 16);
            end
            step();
        end
        start = 1'b0;
        check("sat.done_count", done_cnt, 1);
        check("sat.done_cycle", done_cyc, 21);

        // Reset in the middle of OBSERVE aborts with no done pulse.
        done_cnt = 0;
        start = 1'b1; probe = 3'b000;
        step();
        start = 1'b0;
        for (int n = 1; n <= 30; n++) begin
            probe = (n % 2 == 1) ? 3'b001 : 3'b000;
            if (n == 9) begin
                check("rmid.busy_before", busy, 1);
                check("rmid.cnt_before", toggle_cnt, 4);
            end
            if (n == 10) begin
                rst = 1'b1;
                #1;
                check("rmid.busy", busy, 0);
                check("rmid.done", done, 0);
                check("rmid.rv", result_valid, 0);
                check("rmid.cnt", toggle_cnt, 0);
                check("rmid.mask", toggle_mask, 0);
                check("rmid.cnt3", toggle_cnt3, 0);
            end
            if (n == 11) rst = 1'b0;
            if (n > 11 && busy) done_cnt++;
            if (done) done_cnt++;
            step();
        end
        check("rmid.no_activity", done_cnt, 0);
        run_vec(vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
